// File: rtl/pwm_note_scheduler.sv
// SPI-frame driven note scheduler: synchronises the MCU chip-enable, queues
// ENQUEUE frames in a small FIFO and plays each note as a fixed-period PWM burst.
module pwm_note_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               ce,
  input  logic [47:0]                        frame,
  output logic                               pwm,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY
  } state_t;

  typedef struct packed {
    logic [15:0] per;
    logic [15:0] hi;
    logic [13:0] dur;
  } note_t;

  logic [SYNC_STAGES-1:0] ce_sync_q;
  logic                   ce_prev_q;
  logic                   ce_fall;
  logic                   cmd_enq;
  logic                   cmd_flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_sync_q <= '0;
      ce_prev_q <= 1'b0;
    end else begin
      ce_sync_q <= {ce_sync_q[SYNC_STAGES-2:0], ce};
      ce_prev_q <= ce_sync_q[SYNC_STAGES-1];
    end
  end

  assign ce_fall   = ce_prev_q & ~ce_sync_q[SYNC_STAGES-1];
  assign cmd_enq   = ce_fall && (frame[47:46] == 2'b01);
  assign cmd_flush = ce_fall && (frame[47:46] == 2'b10);

  note_t           mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            fifo_full;
  logic            push;
  logic            pop;
  note_t           head;

  state_t          state_q;
  logic [15:0]     per_q;
  logic [15:0]     hi_q;
  logic [13:0]     dur_q;
  logic [15:0]     phase_q;
  logic [13:0]     rem_q;
  logic            pwm_q;
  logic            busy_q;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign push      = cmd_enq && !fifo_full;
  // Pop decision uses the registered count, so a same-cycle push into an
  // empty FIFO only becomes poppable on the following cycle.
  assign pop       = (state_q == S_IDLE) && (count_q != '0) && !cmd_flush;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (cmd_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (cmd_enq && fifo_full) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= note_t'({frame[45:30], frame[29:14], frame[13:0]});
    end
  end

  // The popped entry is copied on the IDLE->LOAD edge because the read
  // pointer advances on that same edge; LOAD then validates the copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      hi_q    <= '0;
      dur_q   <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (cmd_flush) begin
      state_q <= S_IDLE;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pwm_q <= 1'b0;
          if (pop) begin
            per_q   <= head.per;
            hi_q    <= head.hi;
            dur_q   <= head.dur;
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if ((per_q == '0) || (dur_q == '0)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pwm_q   <= 1'b0;
          end else begin
            phase_q <= '0;
            rem_q   <= dur_q;
            state_q <= S_PLAY;
            busy_q  <= 1'b1;
            pwm_q   <= (hi_q != '0);
          end
        end
        S_PLAY: begin
          if (phase_q == (per_q - 16'd1)) begin
            if (rem_q == 14'd1) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              pwm_q   <= 1'b0;
            end else begin
              rem_q   <= rem_q - 14'd1;
              phase_q <= '0;
              pwm_q   <= (hi_q != '0);
            end
          end else begin
            phase_q <= phase_q + 16'd1;
            pwm_q   <= ((phase_q + 16'd1) < hi_q);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          pwm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pwm        = pwm_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_pwm_note_scheduler.sv
// Bench for pwm_note_scheduler: vector table of single notes plus hand-built
// sequences; a burst monitor checks each played note against a queue of expected notes.
module tb_pwm_note_scheduler;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic [47:0] frame;
  logic        pwm;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  pwm_note_scheduler #(
    .FIFO_DEPTH (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .frame     (frame),
    .pwm       (pwm),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int         p;
    int         h;
    int         d;
    int         exp_len;
    int         exp_high;
    bit         plays;
  } vec_t;

  vec_t tbl [9];
  vec_t sb [$];

  int total = 0;
  int bad = 0;
  int bursts_done = 0;
  int idle_pwm_errs = 0;
  int max_count = 0;
  bit abort_burst = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Burst monitor: one busy burst per popped note.
  bit   in_burst = 0;
  bit   has_cur = 0;
  vec_t cur;
  int   blen, bhigh, perr;
  always @(negedge clk) begin
    if (!reset_n) begin
      in_burst    = 0;
      abort_burst = 0;
    end else begin
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      if (!busy && pwm) idle_pwm_errs++;
      if (busy && !in_burst) begin
        in_burst = 1;
        blen = 0; bhigh = 0; perr = 0;
        if (sb.size() == 0) begin
          has_cur = 0;
          check("unexpected_burst", 1, 0);
        end else begin
          has_cur = 1;
          cur = sb.pop_front();
        end
      end
      if (in_burst && busy) begin
        int e;
        e = 0;
        if (has_cur && cur.p != 0 && blen > 0) e = (((blen - 1) % cur.p) < cur.h) ? 1 : 0;
        if (int'(pwm) != e) perr++;
        bhigh += int'(pwm);
        blen++;
      end else if (in_burst && !busy) begin
        in_burst = 0;
        bursts_done++;
        if (abort_burst) begin
          abort_burst = 0;
        end else if (has_cur) begin
          check($sformatf("burst%0d_len", bursts_done), blen, cur.exp_len);
          check($sformatf("burst%0d_high", bursts_done), bhigh, cur.exp_high);
          check($sformatf("burst%0d_pattern_errs", bursts_done), perr, 0);
        end
      end
    end
  end

  task automatic send_frame(input logic [1:0] op, input int p, input int h, input int d);
    @(negedge clk);
    frame = {op, 16'(p), 16'(h), 14'(d)};
    ce = 1'b1;
    repeat (3) @(negedge clk);
    ce = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=busy%0b/count%0d required=idle", name, busy, fifo_count);
    end
    @(negedge clk);
  endtask

  initial begin
    int   b0, n, pd;
    vec_t r;

    tbl[0] = '{2'b01, 10,  3, 2, 21,  6, 1};
    tbl[1] = '{2'b01,  5,  0, 3, 16,  0, 1};
    tbl[2] = '{2'b01, 10, 12, 1, 11, 10, 1};
    tbl[3] = '{2'b01,  0,  3, 4,  1,  0, 1};
    tbl[4] = '{2'b01,  7,  2, 0,  1,  0, 1};
    tbl[5] = '{2'b01,  1,  1, 3,  4,  3, 1};
    tbl[6] = '{2'b01,  4,  4, 2,  9,  8, 1};
    tbl[7] = '{2'b00, 10,  3, 2,  0,  0, 0};
    tbl[8] = '{2'b11, 10,  3, 2,  0,  0, 0};

    reset_n = 1'b0;
    ce      = 1'b0;
    frame   = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_pwm", int'(pwm), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_overflow", int'(overflow), 0);

    for (int i = 0; i < 9; i++) begin
      b0 = bursts_done;
      if (tbl[i].op == 2'b01) sb.push_back(tbl[i]);
      send_frame(tbl[i].op, tbl[i].p, tbl[i].h, tbl[i].d);
      wait_idle($sformatf("vec%0d_idle", i), 500);
      check($sformatf("vec%0d_count", i), int'(fifo_count), 0);
      check($sformatf("vec%0d_bursts", i), bursts_done - b0, tbl[i].plays ? 1 : 0);
      check($sformatf("vec%0d_overflow", i), int'(overflow), 0);
    end

    // Overflow: note 1 plays while 2..5 fill the FIFO; note 6 is dropped.
    for (int k = 1; k <= 6; k++) begin
      r = '{2'b01, 6, k, 10, 61, 10 * k, 1};
      if (k <= 5) sb.push_back(r);
      send_frame(2'b01, 6, k, 10);
      if (k == 5) begin
        check("ovf_before_full", int'(overflow), 0);
        check("count_full", int'(fifo_count), 4);
      end
      if (k == 6) begin
        check("ovf_set", int'(overflow), 1);
        check("count_after_drop", int'(fifo_count), 4);
      end
    end
    wait_idle("ovf_idle", 1500);
    check("ovf_sticky", int'(overflow), 1);
    check("max_count", max_count, 4);

    // FLUSH mid-PLAY with two notes queued.
    for (int k = 0; k < 3; k++) begin
      r = '{2'b01, 8, 8, 20, 161, 160, 1};
      sb.push_back(r);
      send_frame(2'b01, 8, 8, 20);
    end
    check("pre_flush_count", int'(fifo_count), 2);
    check("pre_flush_pwm", int'(pwm), 1);
    abort_burst = 1;
    sb.delete();
    @(negedge clk);
    frame = {2'b10, 46'd0};
    ce = 1'b1;
    repeat (3) @(negedge clk);
    ce = 1'b0;
    n = 0;
    while (fifo_count != 3'd0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("flush_seen_in_budget", (n < 10) ? 1 : 0, 1);
    check("flush_busy", int'(busy), 0);
    check("flush_pwm", int'(pwm), 0);
    check("flush_overflow", int'(overflow), 0);
    @(negedge clk);
    b0 = bursts_done;
    repeat (20) @(negedge clk);
    check("post_flush_bursts", bursts_done - b0, 0);
    check("post_flush_count", int'(fifo_count), 0);

    // Push lands on the same edge as an IDLE pop with one note queued.
    pd = 30;
    r = '{2'b01, 10, 4, 3, 31, 12, 1};
    sb.push_back(r);
    @(negedge clk);
    frame = {2'b01, 16'd10, 16'd4, 14'd3};
    ce = 1'b1;
    repeat (3) @(negedge clk);
    ce = 1'b0;
    n = 0;
    while (busy != 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("same_cycle_start_in_budget", (n < 20) ? 1 : 0, 1);
    for (int t = 1; t <= pd + 2; t++) begin
      @(negedge clk);
      if (t == 5) begin
        r = '{2'b01, 3, 1, 2, 7, 2, 1};
        sb.push_back(r);
        frame = {2'b01, 16'd3, 16'd1, 14'd2};
        ce = 1'b1;
      end
      if (t == 8) ce = 1'b0;
      if (t == 14) begin
        r = '{2'b01, 2, 1, 4, 9, 4, 1};
        sb.push_back(r);
        frame = {2'b01, 16'd2, 16'd1, 14'd4};
        ce = 1'b1;
      end
      if (t == pd - 1) ce = 1'b0;
      if (t == pd + 1) begin
        check("pop_idle_busy", int'(busy), 0);
        check("pop_idle_count", int'(fifo_count), 1);
      end
      if (t == pd + 2) begin
        check("push_pop_busy", int'(busy), 1);
        check("push_pop_count", int'(fifo_count), 1);
      end
    end
    wait_idle("same_cycle_idle", 500);

    // Asynchronous reset mid-note, released with ce low.
    r = '{2'b01, 10, 10, 5, 51, 50, 1};
    sb.push_back(r);
    send_frame(2'b01, 10, 10, 5);
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_pwm", int'(pwm), 1);
    sb.delete();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_count", int'(fifo_count), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    b0 = bursts_done;
    repeat (12) @(negedge clk);
    check("post_reset_pwm", int'(pwm), 0);
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_count", int'(fifo_count), 0);
    check("post_reset_overflow", int'(overflow), 0);
    check("post_reset_bursts", bursts_done - b0, 0);

    check("idle_pwm_errs", idle_pwm_errs, 0);
    check("scoreboard_left", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_note_scheduler.md
# pwm_note_scheduler

Clock-domain controller between the MCU SPI frame shift register and the `pwm` pin. On each end of transfer, it synchronises the MCU chip-enable and captures the 48-bit flattened MCU frame, then decodes the command. Note frames are queued in a small FIFO and played back one at a time as fixed-period PWM bursts of a programmed duration.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: note queue depth, power of two, at least 2.
- `SYNC_STAGES`, default 2: flops in the `ce` synchroniser, at least 2.

Ports:
- `clk`, in, 1: system clock. Everything in this block is in this domain.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `ce`, in, 1: raw MCU chip-enable, asynchronous. High while a frame is shifting. The falling edge marks the frame complete.
- `frame`, in, 48: flattened MCU frame from the SPI shifter. Stable while `ce` is low.
- `pwm`, out, 1: registered PWM output.
- `busy`, out, 1: high while a note is being loaded or played.
- `fifo_count`, out, $clog2(FIFO_DEPTH+1): number of queued notes.
- `overflow`, out, 1: sticky. Set when an ENQUEUE arrives with the FIFO full.

## Operation
Frame fields:
- `frame[47:46]` opcode: 00 NOP, 01 ENQUEUE, 10 FLUSH, 11 reserved (ignored like NOP).
- `frame[45:30]` period P, in clk cycles.
- `frame[29:14]` high count H, in clk cycles.
- `frame[13:0]` duration D, in PWM periods.

Capture:
- `ce` passes through SYNC_STAGES flops plus one edge-detect flop.
- On a detected 1→0 edge, `frame` is sampled once, in the same cycle, and the opcode is acted on in that cycle.

Commands:
- ENQUEUE: push {P,H,D}. If the FIFO is full, drop the frame and set `overflow`.
- FLUSH: empty the FIFO, abort any note, go to IDLE, drive `pwm` low, and clear `overflow`.
- NOP and reserved opcodes: no effect.

FIFO:
- Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle are legal: `fifo_count` is unchanged and the data stays correct.
- A push into an empty FIFO cannot be popped in that same cycle. It is visible the next cycle.

State machine (IDLE, LOAD, PLAY):
- IDLE: if `fifo_count`≠0, pop and go to LOAD. `pwm`=0, `busy`=0.
- LOAD (1 cycle): latch P, H and D into the working registers.
  - If P==0 or D==0, discard the note and go to IDLE.
  - Otherwise set phase=0, remaining=D, and go to PLAY.
- PLAY:
  - phase increments each cycle and wraps at P−1.
  - On each wrap, remaining decrements.
  - When phase==P−1 and remaining==1, the next state is IDLE.
- Duty rules:
  - `pwm` is high for the first min(H,P) cycles of each period, low otherwise.
  - H==0 gives constant low.
  - H≥P gives constant high for the whole note.
- All counters are 16-bit unsigned (14-bit for remaining). There is no saturation, because the bounds are guaranteed by the checks above.
- FLUSH takes priority over the state machine in any state, including mid-PLAY and LOAD.
- A FLUSH arriving while a pop is in progress wins: the popped note is discarded.

## Timing
Reset values:
- `pwm`=0, `busy`=0, `fifo_count`=0, `overflow`=0.
- State=IDLE, all pointers and counters 0.
- Synchroniser flops reset to 0, so a `ce` low at reset release produces no edge.

Capture latency:
- The edge is detected SYNC_STAGES+1 clk edges after `ce` falls, ±1 for asynchrony.
- `fifo_count` updates on the following edge.

Playback latency and length:
- IDLE→LOAD takes 1 cycle. LOAD→PLAY takes 1 cycle.
- `pwm` first goes high on the first PLAY cycle if H>0.
- A note occupies exactly P·D PLAY cycles.
- The next note's LOAD follows 1 IDLE cycle after the last PLAY cycle.
- `busy` is high throughout LOAD and PLAY.

Other rules:
- `overflow` is set on the edge after the dropped push.
- A second `ce` fall arriving before the first is captured is not supported. The MCU guarantees ≥8 clk cycles between frames.
- An asynchronous reset mid-PLAY drives `pwm` low immediately and clears everything.

## Test plan
- Reset, then ENQUEUE P=10, H=3, D=2 → `pwm` pattern is 3 high then 7 low, twice (20 PLAY cycles); `busy` high for 21 cycles; back to IDLE with `fifo_count`=0.
- ENQUEUE 5 notes back-to-back with FIFO_DEPTH=4 and playback of the first already started → the 5th push is dropped only if the FIFO is full at that moment; `overflow`=1 when dropped; `fifo_count` never exceeds 4.
- Edge cases on a single note: H=0 → `pwm` constant 0 for P·D cycles; H=12 with P=10 → `pwm` constant 1; P=0 or D=0 → no PLAY, one LOAD cycle, `busy` pulse of 1 cycle.
- FLUSH mid-PLAY with 2 notes queued → `pwm`=0 and state IDLE on the next edge; `fifo_count`=0; `overflow` cleared.
- ENQUEUE timed so the push lands on the same cycle as an IDLE pop with `fifo_count`=1 → `fifo_count` stays 1, and the notes play in FIFO order across a pointer wrap.
- Reset asserted mid-note, released with `ce` low → all outputs 0; no spurious capture; NOP and opcode 11 frames leave all state unchanged.
